id_operand_stage: RTL and testbench
===================================

// Module: id_operand_stage
// PURPOSE
// - Decode-stage operand unit of the 5-stage pipeline; drives register-file read addresses and consumes its two read ports.
// - Resolves RAW hazards: forwards from EX/MEM (and optionally WB), detects load-use and stalls one cycle.
// - Registers resolved operands and control into the ID/EX pipeline register for the execute stage.
// - Keeps a saturating stall counter for performance debug.
// PARAMETERS
// - DW    32  datapath width
// - AW    5   register-number width; register 0 is hard zero
// - CNTW  16  stall-counter width
// PORTS
// - clk            in   1    clock, rising edge
// - rst            in   1    asynchronous, active-low reset
// - id_valid       in   1    IF/ID holds a real instruction
// - id_rs, id_rt   in   AW   source register numbers
// - id_use_rs/rt   in   1    instruction actually reads rs / rt
// - id_wn          in   AW   destination register
// - id_wreg        in   1    instruction writes a register
// - id_m2reg       in   1    instruction is a load
// - id_imm         in   DW   sign/zero-extended immediate
// - flush          in   1    branch redirect; kill the instruction in ID
// - rna, rnb       out  AW   register-file read addresses (= id_rs, id_rt, combinational)
// - qa, qb         in   DW   register-file read data
// - ex_wn, ex_wreg, ex_m2reg  in  AW,1,1  instruction now in EX
// - ex_alu         in   DW   EX-stage ALU result
// - mem_wn, mem_wreg in AW,1 instruction now in MEM
// - mem_data       in   DW   MEM-stage result (ALU or load data)
// - wb_wn, wb_wreg in   AW,1 WB write port (same signals as RF write)
// - wb_data        in   DW   WB write data
// - stall          out  1    freeze PC and IF/ID (combinational)
// - idex_valid, idex_a, idex_b, idex_imm, idex_wn, idex_wreg, idex_m2reg  out  ID/EX register
// - stall_cnt      out  CNTW load-use stall cycles since reset
// BEHAVIOUR
// - Reset (rst==0, async): all idex_* = 0, stall_cnt = 0. stall depends only on inputs.
// - Hit rule: source s matches stage X iff X_wreg & X_wn==s & s!=0 & use bit set.
// - Load-use: stall = id_valid & !flush & ex_wreg & ex_m2reg & (hit rs or hit rt vs EX).
// - Forward mux per operand, priority: EX (only when ex_m2reg==0) -> ex_alu;
//   else MEM -> mem_data; else WB (macro) -> wb_data; else qa/qb. s==0 always yields 0.
// - ID/EX update each posedge, priority: flush > stall > normal.
//   - flush or stall: insert bubble (idex_valid=0, idex_wreg=0, idex_m2reg=0); data regs don't-care, hold.
//   - normal: capture forwarded operands, id_imm, id_wn, id_wreg&id_valid, id_m2reg&id_valid, idex_valid=id_valid.
// - Latency: one cycle ID->EX; a load-use costs exactly one bubble, then the MEM forward path resolves it.
// - stall_cnt increments on each posedge with stall==1; saturates at all-ones, never wraps.
// - flush together with a hazard: flush wins, stall=0, no count.
// - Reset mid-operation: async clear, no partial state kept.
// CONFIGURATION
// - WB_BYPASS_EN defined: WB stage is a forward source (lowest priority);
//   same-cycle RF write is visible to ID.
// - WB_BYPASS_EN undefined: no WB path; a WB-only hit on a used source also asserts stall
//   (counted); instruction proceeds next cycle with RF data.
// TESTING
// - Reset: rst=0 mid-run -> idex_valid=0, idex_wreg=0, stall_cnt=0 immediately, no clock.
// - EX forward: ex_wn=3, ex_wreg=1, ex_alu=0x11, rs=3 -> idex_a=0x11 next edge, stall=0.
// - Priority: EX and MEM both target r5 (ex_alu=0xA, mem_data=0xB), rt=5 -> idex_b=0xA.
// - Load-use: ex_m2reg=1, ex_wn=7, rt=7 -> stall=1 one cycle, bubble, stall_cnt=1;
//   next cycle mem_data=0x55 -> idex_b=0x55.
// - r0: ex_wn=0, ex_wreg=1, ex_alu=0xFF, rs=0 -> idex_a=0, stall=0.
// - WB: wb_wn=9, wb_data=0x99, qa stale=0, rs=9 -> with WB_BYPASS_EN idex_a=0x99;
//   without, stall=1 once, then idex_a=RF value.

Source files
------------

// File: rtl/id_operand_stage.sv
// Decode-stage operand unit: RF read addressing, EX/MEM(/WB) forwarding, load-use stall, ID/EX register.
// Latency: one cycle ID->EX; rna/rnb and stall are combinational from the current inputs.
// Backpressure: stall freezes PC and IF/ID and puts a bubble into ID/EX; optional WB bypass via WB_BYPASS_EN.
module id_operand_stage #(
    parameter int DW   = 32,
    parameter int AW   = 5,
    parameter int CNTW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [AW-1:0]   id_rs,
    input  logic [AW-1:0]   id_rt,
    input  logic            id_use_rs,
    input  logic            id_use_rt,
    input  logic [AW-1:0]   id_wn,
    input  logic            id_wreg,
    input  logic            id_m2reg,
    input  logic [DW-1:0]   id_imm,
    input  logic            flush,
    output logic [AW-1:0]   rna,
    output logic [AW-1:0]   rnb,
    input  logic [DW-1:0]   qa,
    input  logic [DW-1:0]   qb,
    input  logic [AW-1:0]   ex_wn,
    input  logic            ex_wreg,
    input  logic            ex_m2reg,
    input  logic [DW-1:0]   ex_alu,
    input  logic [AW-1:0]   mem_wn,
    input  logic            mem_wreg,
    input  logic [DW-1:0]   mem_data,
    input  logic [AW-1:0]   wb_wn,
    input  logic            wb_wreg,
    input  logic [DW-1:0]   wb_data,
    output logic            stall,
    output logic            idex_valid,
    output logic [DW-1:0]   idex_a,
    output logic [DW-1:0]   idex_b,
    output logic [DW-1:0]   idex_imm,
    output logic [AW-1:0]   idex_wn,
    output logic            idex_wreg,
    output logic            idex_m2reg,
    output logic [CNTW-1:0] stall_cnt
);

    // A source matches a producer only if it is really read, is not r0, and the producer writes it.
    function automatic logic hit(input logic [AW-1:0] s, input logic use_s,
                                 input logic [AW-1:0] wn, input logic wreg);
        return wreg && (wn == s) && (s != '0) && use_s;
    endfunction

    logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt, wb_hit_rs, wb_hit_rt;
    logic load_use, wb_stall;
    logic [DW-1:0] fwd_a, fwd_b;

    assign rna = id_rs;
    assign rnb = id_rt;

    assign ex_hit_rs  = hit(id_rs, id_use_rs, ex_wn,  ex_wreg);
    assign ex_hit_rt  = hit(id_rt, id_use_rt, ex_wn,  ex_wreg);
    assign mem_hit_rs = hit(id_rs, id_use_rs, mem_wn, mem_wreg);
    assign mem_hit_rt = hit(id_rt, id_use_rt, mem_wn, mem_wreg);
    assign wb_hit_rs  = hit(id_rs, id_use_rs, wb_wn,  wb_wreg);
    assign wb_hit_rt  = hit(id_rt, id_use_rt, wb_wn,  wb_wreg);

    // Load data is not available until MEM, so an EX load feeding ID must wait one cycle.
    assign load_use = ex_m2reg && (ex_hit_rs || ex_hit_rt);

`ifdef WB_BYPASS_EN
    assign wb_stall = 1'b0;
`else
    // Without a WB path the RF read would be stale; wait one cycle for the write to land.
    assign wb_stall = (wb_hit_rs && !ex_hit_rs && !mem_hit_rs) ||
                      (wb_hit_rt && !ex_hit_rt && !mem_hit_rt);
    logic unused_wb;
    assign unused_wb = ^wb_data;
`endif

    assign stall = id_valid && !flush && (load_use || wb_stall);

    // Operand A: youngest producer wins; r0 always reads as zero.
    always_comb begin
        fwd_a = qa;
        if (id_rs == '0)                    fwd_a = '0;
        else if (ex_hit_rs && !ex_m2reg)    fwd_a = ex_alu;
        else if (mem_hit_rs)                fwd_a = mem_data;
`ifdef WB_BYPASS_EN
        else if (wb_hit_rs)                 fwd_a = wb_data;
`endif
    end

    // Operand B: same priority as operand A.
    always_comb begin
        fwd_b = qb;
        if (id_rt == '0)                    fwd_b = '0;
        else if (ex_hit_rt && !ex_m2reg)    fwd_b = ex_alu;
        else if (mem_hit_rt)                fwd_b = mem_data;
`ifdef WB_BYPASS_EN
        else if (wb_hit_rt)                 fwd_b = wb_data;
`endif
    end

    // ID/EX register: flush or stall inserts a bubble, data fields hold.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idex_valid <= 1'b0;
            idex_a     <= '0;
            idex_b     <= '0;
            idex_imm   <= '0;
            idex_wn    <= '0;
            idex_wreg  <= 1'b0;
            idex_m2reg <= 1'b0;
        end else if (flush || stall) begin
            idex_valid <= 1'b0;
            idex_wreg  <= 1'b0;
            idex_m2reg <= 1'b0;
        end else begin
            idex_valid <= id_valid;
            idex_a     <= fwd_a;
            idex_b     <= fwd_b;
            idex_imm   <= id_imm;
            idex_wn    <= id_wn;
            idex_wreg  <= id_wreg && id_valid;
            idex_m2reg <= id_m2reg && id_valid;
        end
    end

    // Saturating count of stall cycles for performance debug.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            stall_cnt <= '0;
        else if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + {{(CNTW-1){1'b0}}, 1'b1};
    end

endmodule

// File: tb/tb_id_operand_stage.sv
// Directed bench for id_operand_stage: forwarding priority, load-use bubble, r0, flush, WB handling.
// Inputs change 1 time unit after a rising edge; outputs are checked before the next edge.
// Stall counter width is reduced so saturation is reachable in a few cycles.
module tb_id_operand_stage;
    localparam int DW = 32, AW = 5, CNTW = 4;

    logic clk, rst;
    logic id_valid, id_use_rs, id_use_rt, id_wreg, id_m2reg, flush;
    logic [AW-1:0] id_rs, id_rt, id_wn, rna, rnb, ex_wn, mem_wn, wb_wn, idex_wn;
    logic [DW-1:0] id_imm, qa, qb, ex_alu, mem_data, wb_data, idex_a, idex_b, idex_imm;
    logic ex_wreg, ex_m2reg, mem_wreg, wb_wreg;
    logic stall, idex_valid, idex_wreg, idex_m2reg;
    logic [CNTW-1:0] stall_cnt;

    int errors = 0;
    int checks = 0;

    id_operand_stage #(.DW(DW), .AW(AW), .CNTW(CNTW)) dut (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wn(id_wn), .id_wreg(id_wreg),
        .id_m2reg(id_m2reg), .id_imm(id_imm), .flush(flush), .rna(rna), .rnb(rnb),
        .qa(qa), .qb(qb), .ex_wn(ex_wn), .ex_wreg(ex_wreg), .ex_m2reg(ex_m2reg),
        .ex_alu(ex_alu), .mem_wn(mem_wn), .mem_wreg(mem_wreg), .mem_data(mem_data),
        .wb_wn(wb_wn), .wb_wreg(wb_wreg), .wb_data(wb_data), .stall(stall),
        .idex_valid(idex_valid), .idex_a(idex_a), .idex_b(idex_b), .idex_imm(idex_imm),
        .idex_wn(idex_wn), .idex_wreg(idex_wreg), .idex_m2reg(idex_m2reg),
        .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_valid = 1'b1; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
        id_wn = '0; id_wreg = 1'b0; id_m2reg = 1'b0; id_imm = '0; flush = 1'b0;
        qa = '0; qb = '0; ex_wn = '0; ex_wreg = 1'b0; ex_m2reg = 1'b0; ex_alu = '0;
        mem_wn = '0; mem_wreg = 1'b0; mem_data = '0; wb_wn = '0; wb_wreg = 1'b0; wb_data = '0;
    endtask

`ifdef WB_BYPASS_EN
    localparam int CNT_BASE = 1;
`else
    localparam int CNT_BASE = 2;
`endif

    initial begin
        rst = 1'b0;
        clr();
        #2;
        chk("reset_valid", 32'(idex_valid), 32'd0);
        chk("reset_wreg", 32'(idex_wreg), 32'd0);
        chk("reset_cnt", 32'(stall_cnt), 32'd0);
        tick();
        rst = 1'b1;
        tick();

        // Plain instruction, no hazards: RF data passes through.
        clr(); id_rs = 5'd1; id_rt = 5'd2; id_use_rs = 1'b1; id_use_rt = 1'b1;
        qa = 32'h100; qb = 32'h200; id_imm = 32'h7; id_wn = 5'd4; id_wreg = 1'b1;
        #1;
        chk("rna", 32'(rna), 32'd1);
        chk("rnb", 32'(rnb), 32'd2);
        chk("plain_stall", 32'(stall), 32'd0);
        tick();
        chk("plain_a", idex_a, 32'h100);
        chk("plain_b", idex_b, 32'h200);
        chk("plain_imm", idex_imm, 32'h7);
        chk("plain_wn", 32'(idex_wn), 32'd4);
        chk("plain_wreg", 32'(idex_wreg), 32'd1);
        chk("plain_valid", 32'(idex_valid), 32'd1);
        chk("plain_m2reg", 32'(idex_m2reg), 32'd0);

        // EX forward on rs.
        clr(); ex_wn = 5'd3; ex_wreg = 1'b1; ex_alu = 32'h11; id_rs = 5'd3; id_use_rs = 1'b1;
        qa = 32'hDEAD;
        #1 chk("exfwd_stall", 32'(stall), 32'd0);
        tick();
        chk("exfwd_a", idex_a, 32'h11);

        // EX beats MEM on the same register.
        clr(); ex_wn = 5'd5; ex_wreg = 1'b1; ex_alu = 32'hA;
        mem_wn = 5'd5; mem_wreg = 1'b1; mem_data = 32'hB; id_rt = 5'd5; id_use_rt = 1'b1;
        tick();
        chk("prio_b", idex_b, 32'hA);
        ex_wreg = 1'b0;
        tick();
        chk("memfwd_b", idex_b, 32'hB);

        // A load in ID carries m2reg into EX.
        clr(); id_m2reg = 1'b1; id_wreg = 1'b1; id_wn = 5'd8;
        tick();
        chk("load_m2reg", 32'(idex_m2reg), 32'd1);

        // Load-use: one bubble, then MEM forward.
        clr(); ex_m2reg = 1'b1; ex_wreg = 1'b1; ex_wn = 5'd7; id_rt = 5'd7; id_use_rt = 1'b1;
        id_wreg = 1'b1;
        #1 chk("lu_stall", 32'(stall), 32'd1);
        tick();
        chk("lu_bubble_valid", 32'(idex_valid), 32'd0);
        chk("lu_bubble_wreg", 32'(idex_wreg), 32'd0);
        chk("lu_cnt", 32'(stall_cnt), 32'd1);
        ex_m2reg = 1'b0; ex_wreg = 1'b0; mem_wn = 5'd7; mem_wreg = 1'b1; mem_data = 32'h55;
        #1 chk("lu_resolved_stall", 32'(stall), 32'd0);
        tick();
        chk("lu_b", idex_b, 32'h55);
        chk("lu_valid", 32'(idex_valid), 32'd1);

        // r0 is never forwarded.
        clr(); ex_wn = 5'd0; ex_wreg = 1'b1; ex_alu = 32'hFF; id_rs = 5'd0; id_use_rs = 1'b1;
        qa = 32'h123;
        #1 chk("r0_stall", 32'(stall), 32'd0);
        tick();
        chk("r0_a", idex_a, 32'h0);

        // Unused source does not hazard.
        clr(); ex_m2reg = 1'b1; ex_wreg = 1'b1; ex_wn = 5'd7; id_rt = 5'd7; qb = 32'h77;
        #1 chk("nouse_stall", 32'(stall), 32'd0);
        tick();
        chk("nouse_b", idex_b, 32'h77);

        // Flush with a hazard: no stall, bubble, no count.
        id_use_rt = 1'b1; flush = 1'b1; id_wreg = 1'b1;
        #1 chk("flush_stall", 32'(stall), 32'd0);
        tick();
        chk("flush_valid", 32'(idex_valid), 32'd0);
        chk("flush_wreg", 32'(idex_wreg), 32'd0);
        chk("flush_cnt", 32'(stall_cnt), 32'd1);

        // Invalid slot: no stall, nothing written.
        flush = 1'b0; id_valid = 1'b0;
        #1 chk("inv_stall", 32'(stall), 32'd0);
        tick();
        chk("inv_valid", 32'(idex_valid), 32'd0);
        chk("inv_wreg", 32'(idex_wreg), 32'd0);

        // WB-only hit.
        clr(); wb_wn = 5'd9; wb_wreg = 1'b1; wb_data = 32'h99; qa = 32'h0;
        id_rs = 5'd9; id_use_rs = 1'b1;
`ifdef WB_BYPASS_EN
        #1 chk("wb_stall", 32'(stall), 32'd0);
        tick();
        chk("wb_a", idex_a, 32'h99);
`else
        #1 chk("wb_stall", 32'(stall), 32'd1);
        tick();
        chk("wb_bubble", 32'(idex_valid), 32'd0);
        wb_wreg = 1'b0; qa = 32'h99;
        #1 chk("wb_stall_after", 32'(stall), 32'd0);
        tick();
        chk("wb_a", idex_a, 32'h99);
`endif
        chk("wb_cnt", 32'(stall_cnt), 32'(CNT_BASE));

        // Counter saturates at all-ones.
        clr(); ex_m2reg = 1'b1; ex_wreg = 1'b1; ex_wn = 5'd7; id_rs = 5'd7; id_use_rs = 1'b1;
        for (int i = 0; i < 5; i++) tick();
        chk("cnt_mid", 32'(stall_cnt), 32'(CNT_BASE + 5));
        for (int i = 0; i < 15; i++) tick();
        chk("cnt_sat", 32'(stall_cnt), 32'd15);

        // Mid-run async reset.
        clr(); id_wreg = 1'b1;
        tick();
        chk("pre_rst_valid", 32'(idex_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("rst_valid", 32'(idex_valid), 32'd0);
        chk("rst_wreg", 32'(idex_wreg), 32'd0);
        chk("rst_cnt", 32'(stall_cnt), 32'd0);
        rst = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
